sr_bank_writer: RTL and testbench

- Write-side controller for a bank of WIDTH SR flip-flops. The flops are the storage; this block is their writer.
- Accepts a target word over a valid/ready handshake and derives per-bit set/reset excitation from the target and the bank's current state.
- Pulses s_out/r_out for exactly one cycle, then watches the bank's q feedback and reports done or error.
- Sits between control logic and any SR-flop register bank, so callers never hand-build s/r pulses or risk s=r=1.

---
 rtl/sr_bank_writer.sv | 122 ++++++++++++
 tb/tb_sr_bank_writer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sr_bank_writer.sv
`default_nettype none
// ============================================================================
// Module      : sr_bank_writer
// Description : Write-side controller for a bank of SR flip-flops. Accepts a
//               target word, derives per-bit set/reset excitation from the
//               target and the current bank state, pulses it for one cycle,
//               then watches the q feedback and reports done or error.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_bank_writer #(
  parameter int WIDTH    = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask
);

  // Counter is one bit wider than strictly needed so it can never wrap.
  localparam int             CW         = $clog2(MAX_WAIT) + 1;
  localparam logic [CW-1:0]  C_LAST_CNT = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] w_target_nx;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nx;
  logic [WIDTH-1:0] w_s_nx;
  logic [WIDTH-1:0] w_r_nx;
  logic             w_done_nx;
  logic             w_err_nx;
  logic [WIDTH-1:0] w_mask_nx;

  // Handshake and activity flags come straight from the state.
  assign in_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);

  // State register and registered outputs; reset drops excitation at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_target <= '0;
      r_cnt    <= '0;
      s_out    <= '0;
      r_out    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_mask <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_target <= w_target_nx;
      r_cnt    <= w_cnt_nx;
      s_out    <= w_s_nx;
      r_out    <= w_r_nx;
      done     <= w_done_nx;
      err      <= w_err_nx;
      err_mask <= w_mask_nx;
    end
  end

  // Next-state and next-output decode; excitation is zero unless accepting.
  always_comb begin
    w_state_nx  = r_state;
    w_target_nx = r_target;
    w_cnt_nx    = r_cnt;
    w_s_nx      = '0;
    w_r_nx      = '0;
    w_done_nx   = 1'b0;
    w_err_nx    = 1'b0;
    w_mask_nx   = err_mask;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          // Set only bits that must rise, reset only bits that must fall:
          // the two terms are disjoint, so s=r=1 can never be produced.
          w_target_nx = in_data;
          w_s_nx      = in_data & ~q_fb;
          w_r_nx      = ~in_data & q_fb;
          w_mask_nx   = '0;
          w_state_nx  = DRIVE;
        end
      end
      DRIVE: begin
        w_cnt_nx   = '0;
        w_state_nx = CHECK;
      end
      CHECK: begin
        if (q_fb == r_target) begin
          w_done_nx  = 1'b1;
          w_state_nx = IDLE;
        end else if (r_cnt == C_LAST_CNT) begin
          w_err_nx   = 1'b1;
          w_mask_nx  = r_target ^ q_fb;
          w_state_nx = IDLE;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sr_bank_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_bank_writer
// Description : Directed self-checking bench for sr_bank_writer with a
//               behavioural SR bank model (ideal, stuck-at-0, frozen).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_bank_writer;

  localparam int WIDTH    = 8;
  localparam int MAX_WAIT = 4;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] s_out;
  logic [WIDTH-1:0] r_out;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] err_mask;

  // Bank model controls
  logic [WIDTH-1:0] bank;
  logic             bank_load;
  logic [WIDTH-1:0] bank_load_val;
  logic [WIDTH-1:0] stuck0;
  logic             freeze;

  int checks;
  int passes;
  int sr_viol;
  int de_viol;

  sr_bank_writer #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .q_fb     (q_fb),
    .s_out    (s_out),
    .r_out    (r_out),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_mask (err_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SR bank: samples s/r on the rising edge; optional stuck-at-0 bits or freeze.
  always @(posedge clk) begin
    if (bank_load)   bank <= bank_load_val;
    else if (!freeze) bank <= ((bank & ~r_out) | s_out) & ~stuck0;
  end
  assign q_fb = bank;

  // Invariant monitors
  always @(negedge clk) begin
    if ((s_out & r_out) != '0) sr_viol++;
    if (done && err) de_viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bank(input logic [WIDTH-1:0] v);
    bank_load     = 1'b1;
    bank_load_val = v;
    tick();
    bank_load     = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (s_out !== 8'h00 || r_out !== 8'h00) $display("FAIL rst_sr: got s=%h r=%h want 00/00", s_out, r_out); else passes++;
    checks++; if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) $display("FAIL rst_flags: got done=%b err=%b busy=%b want 0/0/0", done, err, busy); else passes++;
    @(negedge clk); reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", in_ready); else passes++;
    checks++; if (err_mask !== 8'h00) $display("FAIL rst_mask: got %h want 00", err_mask); else passes++;
    // Async reset while driving: excitation must vanish before the next edge.
    load_bank(8'h00);
    in_valid = 1'b1; in_data = 8'hFF;
    tick();
    in_valid = 1'b0;
    checks++; if (s_out !== 8'hFF) $display("FAIL rst_pre_drive: got s=%h want ff", s_out); else passes++;
    #2; reset = 1'b1; #1;
    checks++; if (s_out !== 8'h00 || r_out !== 8'h00) $display("FAIL rst_async_sr: got s=%h r=%h want 00/00", s_out, r_out); else passes++;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) $display("FAIL rst_async_flags: got busy=%b done=%b err=%b want 0/0/0", busy, done, err); else passes++;
    @(negedge clk); reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_async_ready: got %b want 1", in_ready); else passes++;
  endtask

  task automatic test_set_clear();
    load_bank(8'hF0);
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    checks++; if (s_out !== 8'h0C || r_out !== 8'hC0) $display("FAIL sc_drive: got s=%h r=%h want 0c/c0", s_out, r_out); else passes++;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL sc_busy: got busy=%b ready=%b want 1/0", busy, in_ready); else passes++;
    tick();
    checks++; if (s_out !== 8'h00 || r_out !== 8'h00 || done !== 1'b0) $display("FAIL sc_check1: got s=%h r=%h done=%b want 00/00/0", s_out, r_out, done); else passes++;
    tick();
    checks++; if (done !== 1'b1 || err !== 1'b0 || in_ready !== 1'b1) $display("FAIL sc_done: got done=%b err=%b ready=%b want 1/0/1", done, err, in_ready); else passes++;
    checks++; if (bank !== 8'h3C) $display("FAIL sc_bank: got %h want 3c", bank); else passes++;
    tick();
    checks++; if (done !== 1'b0) $display("FAIL sc_done_pulse: got %b want 0", done); else passes++;
  endtask

  task automatic test_no_change();
    load_bank(8'hA5);
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    checks++; if (s_out !== 8'h00 || r_out !== 8'h00 || busy !== 1'b1) $display("FAIL nc_drive: got s=%h r=%h busy=%b want 00/00/1", s_out, r_out, busy); else passes++;
    tick();
    checks++; if (s_out !== 8'h00 || r_out !== 8'h00 || done !== 1'b0) $display("FAIL nc_check: got s=%h r=%h done=%b want 00/00/0", s_out, r_out, done); else passes++;
    tick();
    checks++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL nc_done: got done=%b err=%b want 1/0", done, err); else passes++;
  endtask

  task automatic test_stuck();
    stuck0 = 8'h04;
    load_bank(8'h00);
    in_valid = 1'b1; in_data = 8'h04;
    tick();
    in_valid = 1'b0;
    checks++; if (s_out !== 8'h04 || r_out !== 8'h00) $display("FAIL st_drive: got s=%h r=%h want 04/00", s_out, r_out); else passes++;
    for (int i = 0; i < MAX_WAIT; i++) begin
      tick();
      checks++; if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b1) $display("FAIL st_wait%0d: got done=%b err=%b busy=%b want 0/0/1", i, done, err, busy); else passes++;
    end
    tick();
    checks++; if (err !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1) $display("FAIL st_err: got err=%b done=%b ready=%b want 1/0/1", err, done, in_ready); else passes++;
    checks++; if (err_mask !== 8'h04) $display("FAIL st_mask: got %h want 04", err_mask); else passes++;
    tick();
    checks++; if (err !== 1'b0 || err_mask !== 8'h04) $display("FAIL st_hold: got err=%b mask=%h want 0/04", err, err_mask); else passes++;
    stuck0 = 8'h00;
  endtask

  task automatic test_back_to_back();
    load_bank(8'h00);
    in_valid = 1'b1; in_data = 8'h01;
    tick();
    in_data = 8'hFE;
    checks++; if (s_out !== 8'h01 || r_out !== 8'h00) $display("FAIL b2b_drive1: got s=%h r=%h want 01/00", s_out, r_out); else passes++;
    tick();
    checks++; if (in_ready !== 1'b0) $display("FAIL b2b_hold: got ready=%b want 0", in_ready); else passes++;
    tick();
    checks++; if (done !== 1'b1 || in_ready !== 1'b1) $display("FAIL b2b_done1: got done=%b ready=%b want 1/1", done, in_ready); else passes++;
    tick();
    in_valid = 1'b0;
    checks++; if (s_out !== 8'hFE || r_out !== 8'h01 || busy !== 1'b1) $display("FAIL b2b_drive2: got s=%h r=%h busy=%b want fe/01/1", s_out, r_out, busy); else passes++;
    tick();
    tick();
    checks++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL b2b_done2: got done=%b err=%b want 1/0", done, err); else passes++;
    checks++; if (bank !== 8'hFE) $display("FAIL b2b_bank: got %h want fe", bank); else passes++;
    checks++; if (sr_viol !== 0 || de_viol !== 0) $display("FAIL invariants: got sr=%0d de=%0d want 0/0", sr_viol, de_viol); else passes++;
  endtask

  task automatic test_reset_in_check();
    load_bank(8'h00);
    freeze = 1'b1;
    in_valid = 1'b1; in_data = 8'hFF;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b1) $display("FAIL ric_busy: got %b want 1", busy); else passes++;
    #2; reset = 1'b1; #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) $display("FAIL ric_async: got busy=%b done=%b err=%b want 0/0/0", busy, done, err); else passes++;
    tick();
    tick();
    @(negedge clk); reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || err_mask !== 8'h00) $display("FAIL ric_release: got ready=%b mask=%h want 1/00", in_ready, err_mask); else passes++;
    for (int i = 0; i < MAX_WAIT + 2; i++) begin
      tick();
      checks++; if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) $display("FAIL ric_quiet%0d: got done=%b err=%b busy=%b want 0/0/0", i, done, err, busy); else passes++;
    end
    freeze = 1'b0;
  endtask

  initial begin
    checks = 0; passes = 0; sr_viol = 0; de_viol = 0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    bank_load = 1'b0; bank_load_val = '0; stuck0 = '0; freeze = 1'b0;
    test_reset();
    test_set_clear();
    test_no_change();
    test_stuck();
    test_back_to_back();
    test_reset_in_check();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
